snes_bus_sync: RTL and testbench
================================

# snes_bus_sync

Front-end stage of the SNES cartridge interface: synchronizes the asynchronous SNES bus (address, peripheral address, data, /RD, /WR, /PARD, /PAWR, /ROMSEL, CPU clock) into the CLK domain. It publishes a debounced, stable SNES_ADDR/SNES_PA/SNES_ROMSEL set that feeds the address decoder directly, plus single-cycle bus-event strobes that the ROM/SRAM access sequencer and the GSU MMIO logic consume. It is the only place in the design where SNES pins are sampled.

## Interface
- ADDR_STABLE, default 3: consecutive identical CLK samples required before an address is published (legal range 2..15).
- CLK  in  1  system clock; all logic is on its rising edge.
- RST  in  1  reset, asynchronous, active-high.
- SNES_ADDR_IN  in  24  raw CPU address bus.
- SNES_PA_IN  in  8  raw B-bus peripheral address.
- SNES_DATA_IN  in  8  raw data bus.
- SNES_READ_IN, SNES_WRITE_IN, SNES_PARD_IN, SNES_PAWR_IN  in  1 each  raw strobes, active-low.
- SNES_ROMSEL_IN  in  1  raw /ROMSEL.
- SNES_CPU_CLK_IN  in  1  raw CPU clock.
- SNES_ADDR  out  24  published stable address.
- SNES_PA  out  8  peripheral address latched at the PARD/PAWR falling edge.
- SNES_ROMSEL  out  1  /ROMSEL, published together with SNES_ADDR.
- SNES_DATA  out  8  write data latched at the end of a write.
- addr_valid  out  1  high while the published address equals the current sample.
- rd_start, rd_end, wr_start, wr_end  out  1 each  one-cycle A-bus event pulses.
- pa_rd_start, pa_wr_end  out  1 each  one-cycle B-bus event pulses.
- cycle_start  out  1  one-cycle pulse on a CPU clock rising edge.

## Operation
- Every strobe and SNES_CPU_CLK_IN passes through a 2-flop synchronizer. Edges are detected from the synchronized value and its 1-cycle-delayed copy.
- Address path: {ADDR_IN, ROMSEL_IN} is sampled every cycle into hist. A 4-bit stable counter works as follows:
  - Sample equals hist: increment, saturating at ADDR_STABLE-1.
  - Sample differs from hist: clear to 0.
  - When the counter reaches ADDR_STABLE-1, copy the sample into SNES_ADDR/SNES_ROMSEL and assert addr_valid.
  - Any change in the sample deasserts addr_valid on the next cycle. SNES_ADDR holds its old value until the new address is stable.
- A-bus FSM states:
  - ARM: wait until synchronized /RD and /WR are both high, then go to IDLE.
  - IDLE, when /RD is low and addr_valid is high: pulse rd_start, go to READ.
  - IDLE, when /WR is low and addr_valid is high: pulse wr_start, go to WRITE.
  - IDLE, when both /RD and /WR are low: READ wins. WRITE is not entered until the FSM returns to IDLE.
  - IDLE, when a strobe is low but addr_valid is low: stay in IDLE. The start pulse fires on the first cycle where addr_valid is high while the strobe is still low.
  - READ, when /RD rises: pulse rd_end, go to IDLE.
  - WRITE, when /WR rises: pulse wr_end, go to IDLE. On that same cycle SNES_DATA loads the data sample taken 2 cycles earlier, which is aligned with the synchronizer delay.
- B-bus: a falling edge of /PARD latches SNES_PA and pulses pa_rd_start. A falling edge of /PAWR latches SNES_PA. A rising edge of /PAWR pulses pa_wr_end. There is no stability gating on the B-bus.
- cycle_start pulses on each synchronized rising edge of the CPU clock.

## Timing
- Reset values:
  - FSM in ARM.
  - All pulse outputs, addr_valid, SNES_ADDR, SNES_PA and SNES_DATA are 0.
  - SNES_ROMSEL is 1.
  - Synchronizers preset to 1 for the active-low strobes and 0 for the CPU clock.
- A strobe edge on the pins produces its pulse on the 3rd CLK edge after the pin change (2 synchronizer stages plus 1 edge register).
- A new address is published ADDR_STABLE cycles after it first appears on the pins.
- rd_start/wr_start latency is max(3, ADDR_STABLE + 1) cycles after the later of the address change and the strobe fall.
- Every pulse is exactly 1 cycle wide. At most one of rd_start, wr_start, rd_end and wr_end is asserted in any cycle.
- Reset mid-cycle: the FSM restarts in ARM. No end pulse is emitted for the aborted cycle, and no start pulse is emitted until the strobes have been seen inactive.
- A 1-cycle glitch on an address pin clears the stable counter. It causes no publish and no strobe.

## Structure
- Package snes_bus_pkg holds the FSM state encoding (ARM, IDLE, READ, WRITE) and the constant SYNC_STAGES = 2.
- Sub-module sync_edge: 2-flop synchronizer with rise/fall outputs and a parameterized reset value. It is instantiated once per strobe and once for the CPU clock.

## Test plan
- Reset, then hold address 0x00_8000 steady and drive /RD low, then high after 10 cycles → SNES_ADDR = 0x008000, rd_start 1 cycle, rd_end 1 cycle, nothing else pulses.
- Address 0x70_1234 with data 0x5A and a /WR pulse → wr_start, then at wr_end SNES_DATA = 0x5A.
- Toggle address bit 0 for 1 cycle while /RD is high → SNES_ADDR unchanged, addr_valid low for ADDR_STABLE cycles, no pulses.
- Drive /RD low, then assert RST in the middle of the read, release RST, then raise /RD → no rd_end. The next /RD fall gives rd_start.
- Drive /RD and /WR low together → only rd_start and rd_end, with no wr_start.
- /PAWR low with PA = 0x3F → SNES_PA = 0x3F, then pa_wr_end on the /PAWR rise.

Source files
------------

// File: rtl/snes_bus_pkg.sv
// Shared types and constants for the SNES bus front-end.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package snes_bus_pkg;

    // Depth of every pin synchronizer.
    localparam int SYNC_STAGES = 2;

    // A-bus access sequencer states.
    typedef enum logic [1:0] {
        ST_ARM   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } bus_state_e;

endpackage

// File: rtl/sync_edge.sv
// Pin synchronizer with edge detect: sync is the settled level, rise/fall compare it with its 1-cycle-old copy.
// Latency: sync/rise/fall valid SYNC_STAGES cycles after the pin; consumers register the edges (3rd edge overall).
// Backpressure: none, free-running every CLK cycle.
module sync_edge
    import snes_bus_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stg_q, stg_d;
    logic                   dly_q, dly_d;

    // Shift the raw pin through the synchronizer and keep one delayed copy for edges.
    always_comb begin
        stg_d = {stg_q[SYNC_STAGES-2:0], din};
        dly_d = stg_q[SYNC_STAGES-1];
    end

    // Preset to the pin's idle level so reset does not fabricate an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_q <= {SYNC_STAGES{RST_VAL}};
            dly_q <= RST_VAL;
        end else begin
            stg_q <= stg_d;
            dly_q <= dly_d;
        end
    end

    assign sync = stg_q[SYNC_STAGES-1];
    assign rise = sync & ~dly_q;
    assign fall = ~sync & dly_q;

endmodule

// File: rtl/snes_bus_sync.sv
// Samples the SNES cartridge bus into CLK: debounced address publish plus one-cycle bus-event strobes.
// Latency: strobe pulses 3 cycles after the pin edge; address published ADDR_STABLE cycles after it settles.
// Backpressure: none; the SNES bus cannot be stalled, every event is reported as it is seen.
module snes_bus_sync
    import snes_bus_pkg::*;
#(
    parameter int ADDR_STABLE = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [23:0] SNES_ADDR_IN,
    input  logic [7:0]  SNES_PA_IN,
    input  logic [7:0]  SNES_DATA_IN,
    input  logic        SNES_READ_IN,
    input  logic        SNES_WRITE_IN,
    input  logic        SNES_PARD_IN,
    input  logic        SNES_PAWR_IN,
    input  logic        SNES_ROMSEL_IN,
    input  logic        SNES_CPU_CLK_IN,
    output logic [23:0] SNES_ADDR,
    output logic [7:0]  SNES_PA,
    output logic        SNES_ROMSEL,
    output logic [7:0]  SNES_DATA,
    output logic        addr_valid,
    output logic        rd_start,
    output logic        rd_end,
    output logic        wr_start,
    output logic        wr_end,
    output logic        pa_rd_start,
    output logic        pa_wr_end,
    output logic        cycle_start
);

    localparam logic [3:0] CNT_MAX  = 4'(ADDR_STABLE - 1);
    localparam logic [1:0] ARM_WAIT = 2'(SYNC_STAGES);

    logic rd_sync, rd_rise, rd_fall;
    logic wr_sync, wr_rise, wr_fall;
    logic pard_sync, pard_rise, pard_fall;
    logic pawr_sync, pawr_rise, pawr_fall;
    logic cpu_sync, cpu_rise, cpu_fall;

    sync_edge #(.RST_VAL(1'b1)) u_rd   (.clk(CLK), .rst(RST), .din(SNES_READ_IN),    .sync(rd_sync),   .rise(rd_rise),   .fall(rd_fall));
    sync_edge #(.RST_VAL(1'b1)) u_wr   (.clk(CLK), .rst(RST), .din(SNES_WRITE_IN),   .sync(wr_sync),   .rise(wr_rise),   .fall(wr_fall));
    sync_edge #(.RST_VAL(1'b1)) u_pard (.clk(CLK), .rst(RST), .din(SNES_PARD_IN),    .sync(pard_sync), .rise(pard_rise), .fall(pard_fall));
    sync_edge #(.RST_VAL(1'b1)) u_pawr (.clk(CLK), .rst(RST), .din(SNES_PAWR_IN),    .sync(pawr_sync), .rise(pawr_rise), .fall(pawr_fall));
    sync_edge #(.RST_VAL(1'b0)) u_cpu  (.clk(CLK), .rst(RST), .din(SNES_CPU_CLK_IN), .sync(cpu_sync),  .rise(cpu_rise),  .fall(cpu_fall));

    // Edges/levels this stage has no use for.
    logic unused_sigs;
    assign unused_sigs = rd_fall ^ wr_fall ^ pard_rise ^ pard_sync ^ pawr_sync ^ cpu_sync ^ cpu_fall;

    // Address path state.
    logic [24:0] sample;
    logic [24:0] hist_q, hist_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [24:0] pub_q, pub_d;
    logic        valid_q, valid_d;

    // Data/PA delay lines keep bus values aligned with the synchronized strobes.
    logic [7:0] data_s1_q, data_s1_d, data_s2_q, data_s2_d;
    logic [7:0] pa_s1_q, pa_s1_d, pa_s2_q, pa_s2_d;
    logic [7:0] pa_q, pa_d;
    logic       pa_rd_start_q, pa_rd_start_d, pa_wr_end_q, pa_wr_end_d, cycle_start_q, cycle_start_d;

    // FSM state.
    bus_state_e state_q, state_d;
    logic [1:0] arm_cnt_q, arm_cnt_d;
    logic       rd_start_q, rd_start_d, rd_end_q, rd_end_d;
    logic       wr_start_q, wr_start_d, wr_end_q, wr_end_d;
    logic [7:0] dat_q, dat_d;

    assign sample = {SNES_ADDR_IN, SNES_ROMSEL_IN};

    // Debounce: count identical samples, publish once the run reaches ADDR_STABLE.
    always_comb begin
        hist_d  = sample;
        pub_d   = pub_q;
        valid_d = valid_q;
        if (sample != hist_q) begin
            cnt_d   = 4'd0;
            valid_d = 1'b0;
        end else begin
            cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
            if (cnt_d == CNT_MAX) begin
                pub_d   = sample;
                valid_d = 1'b1;
            end
        end
    end

    // B-bus latch, CPU-clock edge and bus-value delay lines; no stability gating here.
    always_comb begin
        data_s1_d     = SNES_DATA_IN;
        data_s2_d     = data_s1_q;
        pa_s1_d       = SNES_PA_IN;
        pa_s2_d       = pa_s1_q;
        pa_d          = (pard_fall || pawr_fall) ? pa_s2_q : pa_q;
        pa_rd_start_d = pard_fall;
        pa_wr_end_d   = pawr_rise;
        cycle_start_d = cpu_rise;
    end

    // A-bus sequencer next state; arm_cnt ignores the synchronizer presets right after reset.
    always_comb begin
        state_d    = state_q;
        arm_cnt_d  = arm_cnt_q;
        rd_start_d = 1'b0;
        rd_end_d   = 1'b0;
        wr_start_d = 1'b0;
        wr_end_d   = 1'b0;
        dat_d      = dat_q;
        case (state_q)
            ST_ARM: begin
                if (arm_cnt_q != ARM_WAIT) begin
                    arm_cnt_d = arm_cnt_q + 2'd1;
                end else if (rd_sync && wr_sync) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!rd_sync && valid_q) begin
                    rd_start_d = 1'b1;
                    state_d    = ST_READ;
                end else if (!wr_sync && valid_q) begin
                    wr_start_d = 1'b1;
                    state_d    = ST_WRITE;
                end
            end
            ST_READ: begin
                if (rd_rise) begin
                    rd_end_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wr_rise) begin
                    wr_end_d = 1'b1;
                    dat_d    = data_s2_q;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    // Address, B-bus and delay-line registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hist_q        <= 25'h1;
            cnt_q         <= 4'd0;
            pub_q         <= 25'h1;
            valid_q       <= 1'b0;
            data_s1_q     <= 8'h00;
            data_s2_q     <= 8'h00;
            pa_s1_q       <= 8'h00;
            pa_s2_q       <= 8'h00;
            pa_q          <= 8'h00;
            pa_rd_start_q <= 1'b0;
            pa_wr_end_q   <= 1'b0;
            cycle_start_q <= 1'b0;
        end else begin
            hist_q        <= hist_d;
            cnt_q         <= cnt_d;
            pub_q         <= pub_d;
            valid_q       <= valid_d;
            data_s1_q     <= data_s1_d;
            data_s2_q     <= data_s2_d;
            pa_s1_q       <= pa_s1_d;
            pa_s2_q       <= pa_s2_d;
            pa_q          <= pa_d;
            pa_rd_start_q <= pa_rd_start_d;
            pa_wr_end_q   <= pa_wr_end_d;
            cycle_start_q <= cycle_start_d;
        end
    end

    // A-bus FSM with registered pulse outputs and write-data capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_ARM;
            arm_cnt_q  <= 2'd0;
            rd_start_q <= 1'b0;
            rd_end_q   <= 1'b0;
            wr_start_q <= 1'b0;
            wr_end_q   <= 1'b0;
            dat_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            arm_cnt_q  <= arm_cnt_d;
            rd_start_q <= rd_start_d;
            rd_end_q   <= rd_end_d;
            wr_start_q <= wr_start_d;
            wr_end_q   <= wr_end_d;
            dat_q      <= dat_d;
        end
    end

    assign SNES_ADDR   = pub_q[24:1];
    assign SNES_ROMSEL = pub_q[0];
    assign addr_valid  = valid_q;
    assign SNES_PA     = pa_q;
    assign SNES_DATA   = dat_q;
    assign rd_start    = rd_start_q;
    assign rd_end      = rd_end_q;
    assign wr_start    = wr_start_q;
    assign wr_end      = wr_end_q;
    assign pa_rd_start = pa_rd_start_q;
    assign pa_wr_end   = pa_wr_end_q;
    assign cycle_start = cycle_start_q;

endmodule

// File: tb/tb_snes_bus_sync.sv
// Directed bench for snes_bus_sync with hand-computed expectations (ADDR_STABLE = 3).
// Latency: n/a.
// Backpressure: n/a.
module tb_snes_bus_sync;

    localparam int AS = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] addr_in = 24'h0;
    logic [7:0]  pa_in = 8'h0;
    logic [7:0]  data_in = 8'h0;
    logic        rd_n = 1'b1, wr_n = 1'b1, pard_n = 1'b1, pawr_n = 1'b1;
    logic        romsel_in = 1'b1, cpu_clk = 1'b0;
    logic [23:0] snes_addr;
    logic [7:0]  snes_pa, snes_data;
    logic        snes_romsel, addr_valid;
    logic        rd_start, rd_end, wr_start, wr_end, pa_rd_start, pa_wr_end, cycle_start;

    snes_bus_sync #(.ADDR_STABLE(AS)) dut (
        .CLK(clk), .RST(rst),
        .SNES_ADDR_IN(addr_in), .SNES_PA_IN(pa_in), .SNES_DATA_IN(data_in),
        .SNES_READ_IN(rd_n), .SNES_WRITE_IN(wr_n), .SNES_PARD_IN(pard_n), .SNES_PAWR_IN(pawr_n),
        .SNES_ROMSEL_IN(romsel_in), .SNES_CPU_CLK_IN(cpu_clk),
        .SNES_ADDR(snes_addr), .SNES_PA(snes_pa), .SNES_ROMSEL(snes_romsel), .SNES_DATA(snes_data),
        .addr_valid(addr_valid),
        .rd_start(rd_start), .rd_end(rd_end), .wr_start(wr_start), .wr_end(wr_end),
        .pa_rd_start(pa_rd_start), .pa_wr_end(pa_wr_end), .cycle_start(cycle_start)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Pulse bookkeeping, sampled on the falling edge.
    int n_rds, n_rde, n_wrs, n_wre, n_pard, n_pawr, n_cyc;
    int f_rds, f_rde, f_wrs, f_wre, f_pawr;
    int n_excl, n_wide;
    logic [6:0] prev_p = 7'h0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        logic [6:0] p;
        p = {rd_start, rd_end, wr_start, wr_end, pa_rd_start, pa_wr_end, cycle_start};
        if (!rst) begin
            if (rd_start)    begin n_rds++;  if (f_rds < 0) f_rds = cyc; end
            if (rd_end)      begin n_rde++;  if (f_rde < 0) f_rde = cyc; end
            if (wr_start)    begin n_wrs++;  if (f_wrs < 0) f_wrs = cyc; end
            if (wr_end)      begin n_wre++;  if (f_wre < 0) f_wre = cyc; end
            if (pa_rd_start) n_pard++;
            if (pa_wr_end)   begin n_pawr++; if (f_pawr < 0) f_pawr = cyc; end
            if (cycle_start) n_cyc++;
            if ((32'(rd_start) + 32'(rd_end) + 32'(wr_start) + 32'(wr_end)) > 1) n_excl++;
            if ((p & prev_p) != 7'h0) n_wide++;
        end
        prev_p = p;
    end

    task automatic clr();
        n_rds = 0; n_rde = 0; n_wrs = 0; n_wre = 0; n_pard = 0; n_pawr = 0; n_cyc = 0;
        f_rds = -1; f_rde = -1; f_wrs = -1; f_wre = -1; f_pawr = -1;
        n_excl = 0; n_wide = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Ticks until addr_valid rises; gives up after 30 so the bench always ends.
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!addr_valid && n < 30);
    endtask

    task automatic chk_clean(input string tag);
        chk({tag, "_excl"}, n_excl, 0);
        chk({tag, "_wide"}, n_wide, 0);
    endtask

    int t0, n, lowc;

    initial begin
        clr();
        // Reset state
        tick(3);
        chk("rst_addr", snes_addr, 24'h0);
        chk("rst_romsel", snes_romsel, 1'b1);
        chk("rst_pa", snes_pa, 8'h0);
        chk("rst_data", snes_data, 8'h0);
        chk("rst_valid", addr_valid, 1'b0);
        chk("rst_pulses", {rd_start, rd_end, wr_start, wr_end, pa_rd_start, pa_wr_end, cycle_start}, 7'h0);
        rst = 1'b0;
        tick(10);

        // Plain read at 0x008000, address latency = ADDR_STABLE
        addr_in = 24'h008000; romsel_in = 1'b0;
        wait_valid(n);
        chk("addr_lat", n, AS);
        chk("rd_addr", snes_addr, 24'h008000);
        chk("rd_romsel", snes_romsel, 1'b0);
        clr();
        rd_n = 1'b0; t0 = cyc;
        tick(10);
        rd_n = 1'b1; n = cyc;
        tick(6);
        chk("rd_start_n", n_rds, 1);
        chk("rd_start_lat", f_rds - t0, 3);
        chk("rd_end_n", n_rde, 1);
        chk("rd_end_lat", f_rde - n, 3);
        chk("rd_other", n_wrs + n_wre + n_pard + n_pawr + n_cyc, 0);
        chk_clean("rd");

        // Write of 0x5A at 0x701234
        addr_in = 24'h701234; romsel_in = 1'b1; data_in = 8'h5A;
        wait_valid(n);
        chk("wr_addr", snes_addr, 24'h701234);
        clr();
        wr_n = 1'b0;
        tick(6);
        wr_n = 1'b1; n = cyc;
        tick(3);
        chk("wr_end_now", wr_end, 1'b1);
        chk("wr_data", snes_data, 8'h5A);
        data_in = 8'h00;
        tick(4);
        chk("wr_data_hold", snes_data, 8'h5A);
        chk("wr_start_n", n_wrs, 1);
        chk("wr_end_n", n_wre, 1);
        chk("wr_end_lat", f_wre - n, 3);
        chk("wr_rd_none", n_rds + n_rde, 0);
        chk_clean("wr");

        // Address and /RD change together: latency ADDR_STABLE+1
        clr();
        addr_in = 24'h00FFC0; romsel_in = 1'b0; rd_n = 1'b0; t0 = cyc;
        tick(8);
        chk("comb_lat", f_rds - t0, AS + 1);
        rd_n = 1'b1;
        tick(6);
        chk("comb_rd_end_n", n_rde, 1);

        // One-cycle glitch on address bit 0
        clr();
        addr_in = 24'h00FFC1;
        tick();
        addr_in = 24'h00FFC0;
        lowc = addr_valid ? 0 : 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!addr_valid) lowc++;
        end
        chk("glitch_low", lowc, AS);
        chk("glitch_addr", snes_addr, 24'h00FFC0);
        chk("glitch_pulses", n_rds + n_rde + n_wrs + n_wre, 0);

        // Reset in the middle of a read
        rd_n = 1'b0;
        tick(8);
        clr();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(8);
        rd_n = 1'b1;
        tick(6);
        chk("mrst_rd_end", n_rde, 0);
        chk("mrst_rd_start", n_rds, 0);
        chk("mrst_addr", snes_addr, 24'h00FFC0);
        clr();
        rd_n = 1'b0; t0 = cyc;
        tick(6);
        chk("mrst_next_start", n_rds, 1);
        chk("mrst_next_lat", f_rds - t0, 3);
        rd_n = 1'b1;
        tick(6);

        // /RD and /WR low together: read wins
        clr();
        rd_n = 1'b0; wr_n = 1'b0;
        tick(8);
        rd_n = 1'b1; wr_n = 1'b1;
        tick(8);
        chk("both_rds", n_rds, 1);
        chk("both_rde", n_rde, 1);
        chk("both_wr", n_wrs + n_wre, 0);
        chk_clean("both");

        // /PAWR with PA 0x3F
        clr();
        pa_in = 8'h3F; pawr_n = 1'b0;
        tick(2);
        chk("pawr_pa_early", snes_pa, 8'h00);
        tick();
        chk("pawr_pa", snes_pa, 8'h3F);
        tick(3);
        pa_in = 8'h11; pawr_n = 1'b1; n = cyc;
        tick(6);
        chk("pawr_end_n", n_pawr, 1);
        chk("pawr_end_lat", f_pawr - n, 3);
        chk("pawr_pa_hold", snes_pa, 8'h3F);
        chk("pawr_pard", n_pard, 0);

        // /PARD with PA 0x21
        clr();
        pa_in = 8'h21; pard_n = 1'b0;
        tick(5);
        pard_n = 1'b1;
        tick(5);
        chk("pard_n", n_pard, 1);
        chk("pard_pa", snes_pa, 8'h21);
        chk("pard_pawr", n_pawr, 0);

        // CPU clock: four rising edges
        clr();
        for (int i = 0; i < 4; i++) begin
            cpu_clk = 1'b1; tick(4);
            cpu_clk = 1'b0; tick(4);
        end
        tick(4);
        chk("cpu_rises", n_cyc, 4);
        chk_clean("cpu");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
